// File: rtl/pipelined_adder.sv
// pipelined_adder
//   WIDTH-bit adder/subtractor broken into STAGES carry chunks of CHUNK = WIDTH/STAGES
//   bits. Each pipeline stage adds one chunk and registers its carry. Operand chunks
//   that have not been added yet ride along with the beat. Sum chunks that are already
//   complete also ride along, so every chunk of a beat leaves the pipe on the same cycle.
//   Valid/ready on both sides; one global advance lets the whole pipe shift or hold.
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   asynchronous reset, active high
//   a, b     in   WIDTH-bit operands
//   c_in     in   carry-in, used in add mode only
//   sub      in   0: a+b+c_in, 1: a-b (computed as a+~b+1)
//   s_valid  in   input beat valid
//   s_ready  out  input accepted this cycle when s_valid is high
//   sum      out  WIDTH-bit result
//   c_out    out  carry out of the MSB (in sub mode, 1 means no borrow)
//   ovf      out  two's-complement signed overflow
//   m_valid  out  output beat valid
//   m_ready  in   downstream accepts the output beat
module pipelined_adder #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   input  logic             sub,
   input  logic             s_valid,
   output logic             s_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf,
   output logic             m_valid,
   input  logic             m_ready
);

   localparam int CHUNK = WIDTH / STAGES;

   logic             adv;
   logic [WIDTH-1:0] b_eff;
   logic             cy_init;

   // The pipe has no internal skid, so every stage moves or holds together.
   assign adv     = m_ready | ~m_valid;
   assign s_ready = adv & ~rst;
   assign b_eff   = sub ? ~b : b;
   assign cy_init = sub | c_in;

   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      // RW: width of the operand chunks that have not been added when the beat enters stage k.
      // SW: width of the completed sum after stage k.
      localparam int RW = (STAGES - k) * CHUNK;
      localparam int SW = (k + 1) * CHUNK;

      logic           v_in;
      logic           cy_in;
      logic [RW-1:0]  a_in;
      logic [RW-1:0]  b_in;
      logic [SW-1:0]  s_in;
      logic [CHUNK:0] add;
      logic           v_q;
      logic           cy_q;
      logic [SW-1:0]  s_q;

      assign add = {1'b0, a_in[CHUNK-1:0]} + {1'b0, b_in[CHUNK-1:0]} + {{CHUNK{1'b0}}, cy_in};

      if (k == 0) begin : g_head
         assign v_in  = s_valid;
         assign cy_in = cy_init;
         assign a_in  = a;
         assign b_in  = b_eff;
         assign s_in  = add[CHUNK-1:0];
      end else begin : g_body
         assign v_in  = g_stg[k-1].v_q;
         assign cy_in = g_stg[k-1].cy_q;
         assign a_in  = g_stg[k-1].g_ops.a_q;
         assign b_in  = g_stg[k-1].g_ops.b_q;
         assign s_in  = {add[CHUNK-1:0], g_stg[k-1].s_q};
      end

      // Data loads only with a valid beat, so bubbles leave the last result on the outputs.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            v_q  <= 1'b0;
            cy_q <= 1'b0;
            s_q  <= '0;
         end else if (adv) begin
            v_q <= v_in;
            if (v_in) begin
               cy_q <= add[CHUNK];
               s_q  <= s_in;
            end
         end
      end

      if (k < STAGES - 1) begin : g_ops
         logic [RW-CHUNK-1:0] a_q;
         logic [RW-CHUNK-1:0] b_q;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               a_q <= '0;
               b_q <= '0;
            end else if (adv && v_in) begin
               a_q <= a_in[RW-1:CHUNK];
               b_q <= b_in[RW-1:CHUNK];
            end
         end
      end else begin : g_tail
         logic ovf_q;

         // The top chunk carries the operand MSBs, so overflow is resolved here.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               ovf_q <= 1'b0;
            end else if (adv && v_in) begin
               ovf_q <= (a_in[RW-1] == b_in[RW-1]) & (add[CHUNK-1] != a_in[RW-1]);
            end
         end
      end
   end

   assign sum     = g_stg[STAGES-1].s_q;
   assign c_out   = g_stg[STAGES-1].cy_q;
   assign m_valid = g_stg[STAGES-1].v_q;
   assign ovf     = g_stg[STAGES-1].g_tail.ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed cases on a 32/4 instance plus randomized
// streaming on 32/4, 32/1 and 8/8 instances against an arithmetic reference model.
module tb_pipelined_adder;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [31:0] a4, b4, sum4;
   logic        cin4, sub4, sv4, sr4, co4, ovf4, mv4, mr4;
   logic [31:0] a1, b1, sum1;
   logic        cin1, sub1, sv1, sr1, co1, ovf1, mv1, mr1;
   logic [7:0]  a8, b8, sum8;
   logic        cin8, sub8, sv8, sr8, co8, ovf8, mv8, mr8;

   pipelined_adder #(.WIDTH(32), .STAGES(4)) u_dut4 (
      .clk(clk), .rst(rst), .a(a4), .b(b4), .c_in(cin4), .sub(sub4),
      .s_valid(sv4), .s_ready(sr4), .sum(sum4), .c_out(co4), .ovf(ovf4),
      .m_valid(mv4), .m_ready(mr4));

   pipelined_adder #(.WIDTH(32), .STAGES(1)) u_dut1 (
      .clk(clk), .rst(rst), .a(a1), .b(b1), .c_in(cin1), .sub(sub1),
      .s_valid(sv1), .s_ready(sr1), .sum(sum1), .c_out(co1), .ovf(ovf1),
      .m_valid(mv1), .m_ready(mr1));

   pipelined_adder #(.WIDTH(8), .STAGES(8)) u_dut8 (
      .clk(clk), .rst(rst), .a(a8), .b(b8), .c_in(cin8), .sub(sub8),
      .s_valid(sv8), .s_ready(sr8), .sum(sum8), .c_out(co8), .ovf(ovf8),
      .m_valid(mv8), .m_ready(mr8));

   int          n_chk = 0;
   int          n_fail = 0;
   int          acc4 = 0, acc1 = 0, acc8 = 0;
   logic [33:0] q4[$], q1[$], q8[$];

   task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: true unsigned and signed arithmetic on w-bit values.
   // Returns {c_out, ovf, sum zero-extended to 32 bits}.
   function automatic logic [33:0] ref_add(input int w, input longint ua, input longint ub,
                                           input bit cin, input bit sb_mode);
      longint m, h, sa, sb, us, sr;
      bit     co, ov;
      m  = longint'(1) << w;
      h  = m >> 1;
      sa = (ua >= h) ? ua - m : ua;
      sb = (ub >= h) ? ub - m : ub;
      if (sb_mode) begin
         us = ua - ub;
         co = (ua >= ub);
         sr = sa - sb;
      end else begin
         us = ua + ub + longint'(cin);
         co = (us >= m);
         sr = sa + sb + longint'(cin);
      end
      if (us < 0) us = us + m;
      us = us % m;
      ov = (sr < -h) || (sr >= h);
      return {co, ov, us[31:0]};
   endfunction

   function automatic logic [31:0] pick32();
      logic [31:0] corners [4];
      corners[0] = 32'h0000_0000;
      corners[1] = 32'hFFFF_FFFF;
      corners[2] = 32'h8000_0000;
      corners[3] = 32'h7FFF_FFFF;
      if ($urandom_range(0, 7) == 0) return corners[$urandom_range(0, 3)];
      return $urandom;
   endfunction

   // Handshakes are predicted at the negedge before the edge that performs them.
   always @(negedge clk) begin
      if (rst) begin
         q4.delete();
         q1.delete();
         q8.delete();
      end else begin
         if (mv4 && mr4) begin
            chk_val("sb4_nonempty", q4.size() != 0, 1);
            if (q4.size() != 0) chk_val("sb4", {co4, ovf4, sum4}, q4.pop_front());
         end
         if (sv4 && sr4) begin
            q4.push_back(ref_add(32, a4, b4, cin4, sub4));
            acc4++;
         end
         if (mv1 && mr1) begin
            chk_val("sb1_nonempty", q1.size() != 0, 1);
            if (q1.size() != 0) chk_val("sb1", {co1, ovf1, sum1}, q1.pop_front());
         end
         if (sv1 && sr1) begin
            q1.push_back(ref_add(32, a1, b1, cin1, sub1));
            acc1++;
         end
         if (mv8 && mr8) begin
            chk_val("sb8_nonempty", q8.size() != 0, 1);
            if (q8.size() != 0) chk_val("sb8", {co8, ovf8, 24'd0, sum8}, q8.pop_front());
         end
         if (sv8 && sr8) begin
            q8.push_back(ref_add(8, a8, b8, cin8, sub8));
            acc8++;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat4(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input logic sb, input logic [31:0] esum, input logic eco,
                        input logic eovf, input string tag);
      int lat;
      a4 = a; b4 = b; cin4 = cin; sub4 = sb; sv4 = 1'b1; mr4 = 1'b1;
      step();
      sv4 = 1'b0;
      lat = 1;
      while (!mv4 && lat < 20) begin
         step();
         lat++;
      end
      chk_val({tag, "_lat"}, lat, 4);
      chk_val({tag, "_sum"}, sum4, esum);
      chk_val({tag, "_cout"}, co4, eco);
      chk_val({tag, "_ovf"}, ovf4, eovf);
      step();
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog expired got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      int in_i, out_i, cyc, cnt;
      logic [31:0] held;
      bit hold_chk;

      a4 = '0; b4 = '0; cin4 = 0; sub4 = 0; sv4 = 0; mr4 = 1;
      a1 = '0; b1 = '0; cin1 = 0; sub1 = 0; sv1 = 0; mr1 = 1;
      a8 = '0; b8 = '0; cin8 = 0; sub8 = 0; sv8 = 0; mr8 = 1;
      rst = 1'b0;
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      chk_val("rst_sready4", sr4, 0);
      chk_val("rst_mvalid4", mv4, 0);
      chk_val("rst_sum4", sum4, 0);
      chk_val("rst_cout4", co4, 0);
      chk_val("rst_ovf4", ovf4, 0);
      chk_val("rst_sready1", sr1, 0);
      chk_val("rst_mvalid1", mv1, 0);
      chk_val("rst_sready8", sr8, 0);
      chk_val("rst_sum8", sum8, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      #1 chk_val("post_rst_sready4", sr4, 1);

      beat4(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "t1_carry");
      beat4(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0, "t1_cin");
      beat4(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, "t2_borrow");
      beat4(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0, "t2_noborrow");
      beat4(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "t3_addovf");
      beat4(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, "t3_subovf");

      in_i = 0; out_i = 0; cyc = 0; hold_chk = 0; held = '0;
      while (out_i < 8 && cyc < 60) begin
         sv4 = (in_i < 8);
         a4 = in_i;
         b4 = in_i * 32'h1000_0001;
         cin4 = 0; sub4 = 0;
         mr4 = !(cyc >= 5 && cyc <= 7);
         @(negedge clk);
         if (hold_chk && mv4) chk_val("t4_hold", sum4, held);
         hold_chk = mv4 && !mr4;
         held = sum4;
         if (mv4 && !mr4) chk_val("t4_full_sready", sr4, 0);
         if (mv4 && mr4) begin
            chk_val("t4_sum", sum4, out_i + out_i * 32'h1000_0001);
            out_i++;
         end
         if (sv4 && sr4) in_i++;
         step();
         cyc++;
      end
      chk_val("t4_count", out_i, 8);
      sv4 = 0; mr4 = 1;
      cnt = 0;
      repeat (6) begin
         step();
         cnt += mv4;
      end
      chk_val("t4_nodup", cnt, 0);

      mr4 = 1;
      for (int i = 0; i < 3; i++) begin
         a4 = 32'h00A0 + i; b4 = 32'h0100; cin4 = 0; sub4 = 0; sv4 = 1;
         step();
      end
      sv4 = 0;
      step();
      chk_val("t5_pre_mvalid", mv4, 1);
      rst = 1'b1;
      @(negedge clk);
      chk_val("t5_rst_mvalid", mv4, 0);
      chk_val("t5_rst_sready", sr4, 0);
      chk_val("t5_rst_sum", sum4, 0);
      step();
      rst = 1'b0;
      cnt = 0;
      repeat (8) begin
         step();
         cnt += mv4;
      end
      chk_val("t5_stale", cnt, 0);
      beat4(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, "t5_post");

      acc4 = 0; acc1 = 0; acc8 = 0;
      cyc = 0;
      while ((acc4 < 1000 || acc1 < 1000 || acc8 < 1000) && cyc < 6000) begin
         sv4 = ($urandom_range(0, 3) != 0); mr4 = ($urandom_range(0, 3) != 0);
         a4 = pick32(); b4 = pick32(); cin4 = $urandom_range(0, 1); sub4 = $urandom_range(0, 1);
         sv1 = ($urandom_range(0, 3) != 0); mr1 = ($urandom_range(0, 3) != 0);
         a1 = pick32(); b1 = pick32(); cin1 = $urandom_range(0, 1); sub1 = $urandom_range(0, 1);
         sv8 = ($urandom_range(0, 3) != 0); mr8 = ($urandom_range(0, 3) != 0);
         a8 = 8'($urandom); b8 = 8'($urandom); cin8 = $urandom_range(0, 1); sub8 = $urandom_range(0, 1);
         step();
         cyc++;
      end
      chk_val("t6_acc4", acc4 >= 1000, 1);
      chk_val("t6_acc1", acc1 >= 1000, 1);
      chk_val("t6_acc8", acc8 >= 1000, 1);
      sv4 = 0; mr4 = 1; sv1 = 0; mr1 = 1; sv8 = 0; mr8 = 1;
      repeat (12) step();
      chk_val("t6_drain4", q4.size(), 0);
      chk_val("t6_drain1", q1.size(), 0);
      chk_val("t6_drain8", q8.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
